// File: rtl/ans_encoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ans_encoder_if : symbol-in / nibble-out handshake bundle for ans_encoder |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface ans_encoder_if #(
   parameter int SYM_WIDTH = 4
);
   logic [SYM_WIDTH-1:0] in;
   logic                 in_last;
   logic                 in_vld;
   logic                 in_rdy;
   logic [SYM_WIDTH-1:0] out;
   logic                 out_last;
   logic                 out_vld;
   logic                 out_rdy;

   modport master (
      output in, in_last, in_vld, out_rdy,
      input  in_rdy, out, out_last, out_vld
   );

   modport slave (
      input  in, in_last, in_vld, out_rdy,
      output in_rdy, out, out_last, out_vld
   );
endinterface
`default_nettype wire

// File: rtl/ans_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ans_encoder : streaming rANS encoder, renorm nibbles then LSB-first flush |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ans_encoder #(
   parameter int SYM_WIDTH   = 4,
   parameter int SYM_COUNT   = 16,
   parameter int CNT_WIDTH   = 9,
   parameter int PROB_BITS   = 8,
   parameter int STATE_WIDTH = 16
) (
   input  wire logic                           clk,
   input  wire logic                           rst,
   input  wire logic                           en,
   ans_encoder_if.slave                        bus,
   input  wire logic [CNT_WIDTH*SYM_COUNT-1:0] counts_unpacked,
   output logic                                err
);
   localparam int NIBS  = STATE_WIDTH / SYM_WIDTH;
   localparam int NIB_W = $clog2(NIBS + 1);
   localparam int DIV_W = $clog2(STATE_WIDTH + 1);
   localparam logic [STATE_WIDTH-1:0] X_INIT = {4'b0001, {(STATE_WIDTH-4){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_RENORM, S_DIVIDE, S_UPDATE, S_FLUSH
   } state_t;

   state_t                 r_state;
   logic [STATE_WIDTH-1:0] r_x, r_dvd, r_c;
   logic [STATE_WIDTH:0]   r_xmax;
   logic [CNT_WIDTH-1:0]   r_f;
   logic [CNT_WIDTH:0]     r_rem;
   logic [DIV_W-1:0]       r_cnt;
   logic [NIB_W-1:0]       r_nib;
   logic [SYM_WIDTH-1:0]   r_sym, r_out;
   logic                   r_last, r_in_rdy, r_out_last, r_out_vld, r_err;

   logic [CNT_WIDTH-1:0]   w_f;
   logic [STATE_WIDTH-1:0] w_c, w_x_sh, w_new_x;
   logic [STATE_WIDTH:0]   w_xmax;
   logic [CNT_WIDTH:0]     w_rem_sh, w_rem_nx;
   logic                   w_ge;

   // Frequency lookup and prefix sum for the latched symbol
   always_comb begin
      w_f = counts_unpacked[r_sym*CNT_WIDTH +: CNT_WIDTH];
      w_c = '0;
      for (int i = 0; i < SYM_COUNT; i++) begin
         if (SYM_WIDTH'(i) < r_sym)
            w_c = w_c + {{(STATE_WIDTH-CNT_WIDTH){1'b0}}, counts_unpacked[i*CNT_WIDTH +: CNT_WIDTH]};
      end
      w_xmax = {{(STATE_WIDTH+1-CNT_WIDTH){1'b0}}, w_f} << (STATE_WIDTH - PROB_BITS);
   end

   // Restoring divider: remainder stays below f, so one extra bit holds the shifted value
   always_comb begin
      w_rem_sh = {r_rem[CNT_WIDTH-1:0], r_dvd[STATE_WIDTH-1]};
      w_ge     = (w_rem_sh >= {1'b0, r_f});
      w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_f}) : w_rem_sh;
      w_x_sh   = r_x >> SYM_WIDTH;
      w_new_x  = (r_dvd << PROB_BITS) + {{(STATE_WIDTH-CNT_WIDTH-1){1'b0}}, r_rem} + r_c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_x        <= X_INIT;
         r_dvd      <= '0;
         r_c        <= '0;
         r_xmax     <= '0;
         r_f        <= '0;
         r_rem      <= '0;
         r_cnt      <= '0;
         r_nib      <= '0;
         r_sym      <= '0;
         r_last     <= 1'b0;
         r_in_rdy   <= 1'b1;
         r_out      <= '0;
         r_out_last <= 1'b0;
         r_out_vld  <= 1'b0;
         r_err      <= 1'b0;
      end else if (en) begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_vld && r_in_rdy) begin
                  r_sym    <= bus.in;
                  r_last   <= bus.in_last;
                  r_in_rdy <= 1'b0;
                  r_state  <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               r_f    <= w_f;
               r_c    <= w_c;
               r_xmax <= w_xmax;
               if (w_f == '0) begin
                  r_err <= 1'b1;
                  if (r_last) begin
                     r_out      <= r_x[SYM_WIDTH-1:0];
                     r_out_vld  <= 1'b1;
                     r_out_last <= 1'b0;
                     r_nib      <= '0;
                     r_state    <= S_FLUSH;
                  end else begin
                     r_in_rdy <= 1'b1;
                     r_state  <= S_IDLE;
                  end
               end else if ({1'b0, r_x} >= w_xmax) begin
                  r_out      <= r_x[SYM_WIDTH-1:0];
                  r_out_vld  <= 1'b1;
                  r_out_last <= 1'b0;
                  r_state    <= S_RENORM;
               end else begin
                  r_dvd   <= r_x;
                  r_rem   <= '0;
                  r_cnt   <= '0;
                  r_state <= S_DIVIDE;
               end
            end
            S_RENORM: begin
               if (bus.out_rdy) begin
                  r_x <= w_x_sh;
                  if ({1'b0, w_x_sh} >= r_xmax) begin
                     r_out <= w_x_sh[SYM_WIDTH-1:0];
                  end else begin
                     r_out_vld <= 1'b0;
                     r_dvd     <= w_x_sh;
                     r_rem     <= '0;
                     r_cnt     <= '0;
                     r_state   <= S_DIVIDE;
                  end
               end
            end
            S_DIVIDE: begin
               r_dvd <= {r_dvd[STATE_WIDTH-2:0], w_ge};
               r_rem <= w_rem_nx;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == DIV_W'(STATE_WIDTH - 1))
                  r_state <= S_UPDATE;
            end
            S_UPDATE: begin
               r_x <= w_new_x;
               if (r_last) begin
                  r_out      <= w_new_x[SYM_WIDTH-1:0];
                  r_out_vld  <= 1'b1;
                  r_out_last <= 1'b0;
                  r_nib      <= '0;
                  r_state    <= S_FLUSH;
               end else begin
                  r_in_rdy <= 1'b1;
                  r_state  <= S_IDLE;
               end
            end
            S_FLUSH: begin
               if (bus.out_rdy) begin
                  if (r_nib == NIB_W'(NIBS - 1)) begin
                     r_x        <= X_INIT;
                     r_out_vld  <= 1'b0;
                     r_out_last <= 1'b0;
                     r_in_rdy   <= 1'b1;
                     r_state    <= S_IDLE;
                  end else begin
                     r_x        <= w_x_sh;
                     r_out      <= w_x_sh[SYM_WIDTH-1:0];
                     r_out_last <= (r_nib == NIB_W'(NIBS - 2));
                     r_nib      <= r_nib + 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_rdy   = r_in_rdy;
   assign bus.out      = r_out;
   assign bus.out_last = r_out_last;
   assign bus.out_vld  = r_out_vld;
   assign err          = r_err;
endmodule
`default_nettype wire
